// File: rtl/adc_pkg.sv
// Shared types and frame constants for the ADC serial frame responder.
package adc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int FRAME_BITS = 16;
  localparam int LEAD_ZEROS = 4;
  localparam int BIT_CNT_W  = 4;

  // bit_cnt values at which the two address bits arrive on din
  localparam logic [BIT_CNT_W-1:0] ADDR_BIT1 = 4'd12;
  localparam logic [BIT_CNT_W-1:0] ADDR_BIT0 = 4'd11;
  localparam logic [BIT_CNT_W-1:0] CNT_LAST  = 4'd15;

endpackage

// File: rtl/adc_edge_detect.sv
// One-flop history on sclk and cs_n, producing single-cycle edge strobes.
module adc_edge_detect (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_sclk,
  input  logic i_cs_n,
  output logic o_rise,
  output logic o_fall,
  output logic o_cs_fall,
  output logic o_cs_rise
);

  logic r_sclk_q;
  logic r_cs_q;

  // History flops; cs_q resets high so a low cs_n right after reset starts a frame
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_sclk_q <= 1'b1;
      r_cs_q   <= 1'b1;
    end else begin
      r_sclk_q <= i_sclk;
      r_cs_q   <= i_cs_n;
    end
  end

  assign o_rise    =  i_sclk & ~r_sclk_q;
  assign o_fall    = ~i_sclk &  r_sclk_q;
  assign o_cs_fall = ~i_cs_n &  r_cs_q;
  assign o_cs_rise =  i_cs_n & ~r_cs_q;

endmodule

// File: rtl/adc_spi_responder.sv
// ADC-style serial responder: 16-clock frame, 4 leading zeros then a
// DATA_W-bit sample MSB-first. The sample sent belongs to the channel
// addressed in the previous completed frame.
// Optional build macro ADC_RESP_TEST_PATTERN_EN replaces ch_data with
// per-channel incrementing counters {ch, count}.
module adc_spi_responder
  import adc_pkg::*;
#(
  parameter int DATA_W = 12,
  parameter int ADDR_W = 2
) (
  input  logic                           i_clk,
  input  logic                           i_reset,
  input  logic                           i_sclk,
  input  logic                           i_cs_n,
  input  logic                           i_din,
  input  logic [(2**ADDR_W)*DATA_W-1:0]  i_ch_data,
  output logic                           o_dout,
  output logic [ADDR_W-1:0]              o_cur_addr,
  output logic                           o_frame_done,
  output logic                           o_frame_err
);

  localparam int NUM_CH = 2**ADDR_W;
  localparam int TX_W   = DATA_W + LEAD_ZEROS;

  logic w_rise;
  logic w_fall;
  logic w_cs_fall;
  logic w_cs_rise;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic                   w_frame_done;
  logic                   w_abort;
  logic [BIT_CNT_W-1:0]   r_bit_cnt;
  logic [TX_W-1:0]        r_tx_shift;
  logic [ADDR_W-1:0]      r_cur_addr;
  logic [ADDR_W-1:0]      r_addr_nxt;
  logic                   r_frame_err;
  logic [DATA_W-1:0]      w_sample;

  adc_edge_detect u_edge (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_sclk    (i_sclk),
    .i_cs_n    (i_cs_n),
    .o_rise    (w_rise),
    .o_fall    (w_fall),
    .o_cs_fall (w_cs_fall),
    .o_cs_rise (w_cs_rise)
  );

`ifdef ADC_RESP_TEST_PATTERN_EN
  logic [DATA_W-ADDR_W-1:0] r_pat_cnt [NUM_CH];
  logic                     w_unused_ch_data;

  assign w_unused_ch_data = ^i_ch_data;
  assign w_sample         = {r_cur_addr, r_pat_cnt[r_cur_addr]};

  // Pattern counters advance only for the channel whose frame completed
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < NUM_CH; i++) r_pat_cnt[i] <= '0;
    end else if (r_state == DONE) begin
      r_pat_cnt[r_cur_addr] <= r_pat_cnt[r_cur_addr] + 1'b1;
    end
  end
`else
  assign w_sample = i_ch_data[r_cur_addr*DATA_W +: DATA_W];
`endif

  // State register
  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= IDLE;
    else         r_state <= w_state_nxt;
  end

  // Next-state decode; the final rise beats a simultaneous cs_rise
  always_comb begin
    w_state_nxt  = r_state;
    w_frame_done = 1'b0;
    w_abort      = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_cs_fall) w_state_nxt = SHIFT;
      end
      SHIFT: begin
        if (w_rise && (r_bit_cnt == '0)) begin
          w_state_nxt = DONE;
        end else if (w_cs_rise) begin
          w_state_nxt = IDLE;
          w_abort     = 1'b1;
        end
      end
      DONE: begin
        w_frame_done = 1'b1;
        w_state_nxt  = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Frame datapath: sample load, bit counting, address capture, output shift
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_bit_cnt   <= CNT_LAST;
      r_tx_shift  <= '0;
      r_cur_addr  <= '0;
      r_addr_nxt  <= '0;
      r_frame_err <= 1'b0;
    end else begin
      r_frame_err <= w_abort;
      case (r_state)
        IDLE: begin
          if (w_cs_fall) begin
            r_bit_cnt  <= CNT_LAST;
            r_tx_shift <= {{LEAD_ZEROS{1'b0}}, w_sample};
          end
        end
        SHIFT: begin
          if (!w_abort) begin
            if (w_rise) begin
              if (r_bit_cnt == ADDR_BIT1) r_addr_nxt[1] <= i_din;
              if (r_bit_cnt == ADDR_BIT0) r_addr_nxt[0] <= i_din;
              r_bit_cnt <= r_bit_cnt - 1'b1;
            end
            if (w_fall) r_tx_shift <= {r_tx_shift[TX_W-2:0], 1'b0};
          end
        end
        DONE: begin
          r_cur_addr <= r_addr_nxt;
        end
        default: ;
      endcase
    end
  end

  assign o_dout       = (r_state == SHIFT) & r_tx_shift[TX_W-1];
  assign o_cur_addr   = r_cur_addr;
  assign o_frame_done = w_frame_done;
  assign o_frame_err  = r_frame_err;

endmodule

// File: tb/tb_adc_spi_responder.sv
// Bench for adc_spi_responder: frame-level reference model plus per-cycle compare.
module tb_adc_spi_responder;

  localparam int DATA_W = 12;
  localparam int ADDR_W = 2;
  localparam int NUM_CH = 4;

  logic                     i_clk = 1'b0;
  logic                     i_reset;
  logic                     i_sclk;
  logic                     i_cs_n;
  logic                     i_din;
  logic [NUM_CH*DATA_W-1:0] i_ch_data;
  logic                     o_dout;
  logic [ADDR_W-1:0]        o_cur_addr;
  logic                     o_frame_done;
  logic                     o_frame_err;

  int n_err = 0;
  int n_chk = 0;

  // Reference model state: what the outputs must be in the current cycle
  logic [DATA_W-1:0] m_ch [NUM_CH];
  logic [1:0]        m_cur_addr;
  logic              m_dout;
  logic              m_done;
  logic              m_err;
  logic              chk_en = 1'b0;
`ifdef ADC_RESP_TEST_PATTERN_EN
  int                m_cnt [NUM_CH];
`endif

  always #5 i_clk = ~i_clk;

  adc_spi_responder #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_sclk       (i_sclk),
    .i_cs_n       (i_cs_n),
    .i_din        (i_din),
    .i_ch_data    (i_ch_data),
    .o_dout       (o_dout),
    .o_cur_addr   (o_cur_addr),
    .o_frame_done (o_frame_done),
    .o_frame_err  (o_frame_err)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [DATA_W-1:0] model_sample(input logic [1:0] ch);
`ifdef ADC_RESP_TEST_PATTERN_EN
    return {ch, 10'(m_cnt[ch])};
`else
    return m_ch[ch];
`endif
  endfunction

  task automatic put_ch(input int ch, input logic [DATA_W-1:0] v);
    m_ch[ch] = v;
    i_ch_data[ch*DATA_W +: DATA_W] = v;
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic model_reset();
    m_cur_addr = 2'd0;
    m_dout     = 1'b0;
    m_done     = 1'b0;
    m_err      = 1'b0;
`ifdef ADC_RESP_TEST_PATTERN_EN
    for (int c = 0; c < NUM_CH; c++) m_cnt[c] = 0;
`endif
  endtask

  // Per-cycle compare of every output against the model
  always @(negedge i_clk) begin
    if (chk_en && !i_reset) begin
      check("dout",       32'(o_dout),       32'(m_dout));
      check("cur_addr",   32'(o_cur_addr),   32'(m_cur_addr));
      check("frame_done", 32'(o_frame_done), 32'(m_done));
      check("frame_err",  32'(o_frame_err),  32'(m_err));
    end
  end

  // mode 0: complete frame; 1: cs_n raised after n_rise rises; 2: reset after n_rise rises
  task automatic run_frame(input logic [1:0] addr, input int mode, input int n_rise,
                           input bit cs_last, input int chg_at, input logic [DATA_W-1:0] chg_val,
                           output logic [15:0] got);
    logic [15:0] w;
    logic [1:0]  sent;
    int          nr;
    sent = m_cur_addr;
    w    = {4'h0, model_sample(sent)};
    got  = '0;
    nr   = (mode == 0) ? 16 : n_rise;
    i_cs_n = 1'b0;
    m_dout = 1'b0;
    tick();
    for (int i = 0; i < nr; i++) begin
      i_sclk = 1'b1;
      i_din  = (i == 3) ? addr[1] : (i == 4) ? addr[0] : 1'($urandom);
      if (i == chg_at) put_ch(32'(sent), chg_val);
      if (mode == 0 && cs_last && i == 15) i_cs_n = 1'b1;
      m_dout = w[15-i];
      @(negedge i_clk);
      got[15-i] = o_dout;
      tick();
      i_sclk = 1'b0;
      if (mode == 0 && i == 15) begin
        m_dout = 1'b0;
        m_done = 1'b1;
        i_cs_n = 1'b1;
        tick();
        m_done     = 1'b0;
        m_cur_addr = addr;
`ifdef ADC_RESP_TEST_PATTERN_EN
        m_cnt[sent] = m_cnt[sent] + 1;
`endif
        tick();
      end else begin
        tick();
      end
    end
    if (mode == 1) begin
      i_cs_n = 1'b1;
      m_dout = w[15-nr];
      tick();
      m_dout = 1'b0;
      m_err  = 1'b1;
      tick();
      m_err = 1'b0;
      tick();
    end else if (mode == 2) begin
      i_reset = 1'b1;
      i_cs_n  = 1'b1;
      tick();
      i_reset = 1'b0;
      model_reset();
      tick();
    end
  endtask

  initial begin
    logic [15:0] got;
    int          md;
    i_reset   = 1'b1;
    i_sclk    = 1'b0;
    i_cs_n    = 1'b1;
    i_din     = 1'b0;
    i_ch_data = '0;
    for (int c = 0; c < NUM_CH; c++) m_ch[c] = '0;
    model_reset();
    repeat (3) tick();
    i_reset = 1'b0;
    chk_en  = 1'b1;
    tick();
    check("rst_dout",     32'(o_dout),       32'd0);
    check("rst_cur_addr", 32'(o_cur_addr),   32'd0);
    check("rst_done",     32'(o_frame_done), 32'd0);
    check("rst_err",      32'(o_frame_err),  32'd0);

    put_ch(0, 12'hABC);
    put_ch(1, 12'h5A5);
    put_ch(2, 12'h123);
    put_ch(3, 12'h3C3);

`ifdef ADC_RESP_TEST_PATTERN_EN
    run_frame(2'b11, 0, 0, 1'b0, -1, '0, got);
    check("pat_ch0_first", 32'(got), 32'h0000);
    run_frame(2'b11, 0, 0, 1'b0, -1, '0, got);
    check("pat_ch3_0", 32'(got), 32'h0C00);
    run_frame(2'b11, 0, 0, 1'b0, -1, '0, got);
    check("pat_ch3_1", 32'(got), 32'h0C01);
    run_frame(2'b11, 1, 8, 1'b0, -1, '0, got);
    run_frame(2'b11, 0, 0, 1'b0, -1, '0, got);
    check("pat_ch3_2", 32'(got), 32'h0C02);
    run_frame(2'b11, 0, 0, 1'b0, -1, '0, got);
    check("pat_ch3_3", 32'(got), 32'h0C03);
    run_frame(2'b10, 2, 9, 1'b0, -1, '0, got);
    run_frame(2'b11, 0, 0, 1'b0, -1, '0, got);
    check("pat_after_rst_ch0", 32'(got), 32'h0000);
    run_frame(2'b11, 0, 0, 1'b0, -1, '0, got);
    check("pat_after_rst_ch3", 32'(got), 32'h0C00);
`else
    run_frame(2'b10, 0, 0, 1'b0, -1, '0, got);
    check("f1_word", 32'(got), 32'h0ABC);
    check("f1_addr", 32'(o_cur_addr), 32'd2);
    run_frame(2'b01, 0, 0, 1'b0, -1, '0, got);
    check("f2_word", 32'(got), 32'h0123);
    check("f2_addr", 32'(o_cur_addr), 32'd1);
    run_frame(2'b11, 1, 8, 1'b0, -1, '0, got);
    check("abort_addr", 32'(o_cur_addr), 32'd1);
    run_frame(2'b00, 0, 0, 1'b0, -1, '0, got);
    check("after_abort_word", 32'(got), 32'h05A5);
    check("after_abort_addr", 32'(o_cur_addr), 32'd0);
    put_ch(0, 12'h0F0);
    run_frame(2'b00, 0, 0, 1'b0, 5, 12'hFFF, got);
    check("midframe_word", 32'(got), 32'h00F0);
    run_frame(2'b10, 2, 9, 1'b0, -1, '0, got);
    check("rst_mid_dout", 32'(o_dout), 32'd0);
    check("rst_mid_addr", 32'(o_cur_addr), 32'd0);
    run_frame(2'b11, 0, 0, 1'b0, -1, '0, got);
    check("post_rst_word", 32'(got), 32'h0FFF);
    check("post_rst_addr", 32'(o_cur_addr), 32'd3);
    run_frame(2'b01, 0, 0, 1'b1, -1, '0, got);
    check("cs_last_word", 32'(got), 32'h03C3);
    check("cs_last_addr", 32'(o_cur_addr), 32'd1);
`endif

    for (int k = 0; k < 40; k++) begin
      for (int c = 0; c < NUM_CH; c++) put_ch(c, 12'($urandom));
      md = $urandom_range(0, 9);
      md = (md < 7) ? 0 : (md < 9) ? 1 : 2;
      run_frame(2'($urandom), md, $urandom_range(0, 15), 1'($urandom),
                $urandom_range(0, 20), 12'($urandom), got);
    end

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, errors=%0d checks=%0d", n_err, n_chk);
    $fatal(1, "watchdog expired");
  end

endmodule
